// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B) writeback,
// with a pending-write scoreboard for decode hazard queries.
module regwr_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             aValid,
    input  logic [4:0]       aReg,
    input  logic [WIDTH-1:0] aData,
    output logic             aReady,
    input  logic             bValid,
    input  logic [4:0]       bReg,
    input  logic [WIDTH-1:0] bData,
    output logic             bReady,
    input  logic             allocEn,
    input  logic [4:0]       allocReg,
    input  logic [4:0]       qReg0,
    input  logic [4:0]       qReg1,
    output logic             busy0,
    output logic             busy1,
    output logic [5:0]       pendCount,
    output logic [WIDTH-1:0] writeData,
    output logic [4:0]       writeReg,
    output logic             regWrEn
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e      r_lastGrant;
    logic [30:0] r_pending;
    logic [5:0]  r_pendCount;

    logic        w_grantA;
    logic        w_grantB;
    logic        w_grant;
    logic [4:0]  w_wrReg;
    logic [31:0] w_pendFull;
    logic [31:0] w_pendNext;
    logic        w_allocOk;
    logic        w_wrOk;
    logic        w_set;
    logic        w_clr;

    // Bit 31 is a permanent zero so register 31 can be indexed without special cases.
    assign w_pendFull = {1'b0, r_pending};

    always_comb begin
        w_grantA = reset_n && aValid && (!bValid || (r_lastGrant == GRANT_B));
        w_grantB = reset_n && bValid && !w_grantA;
        w_grant  = w_grantA || w_grantB;
        w_wrReg  = '0;
        if (w_grantA) begin
            w_wrReg = aReg;
        end else if (w_grantB) begin
            w_wrReg = bReg;
        end
    end

    always_comb begin
        aReady    = w_grantA;
        bReady    = w_grantB;
        writeReg  = w_wrReg;
        writeData = '0;
        if (w_grantA) begin
            writeData = aData;
        end else if (w_grantB) begin
            writeData = bData;
        end
        regWrEn   = w_grant && (w_wrReg != 5'd31);
        busy0     = w_pendFull[qReg0];
        busy1     = w_pendFull[qReg1];
        pendCount = r_pendCount;
    end

    // Clear from the accepted write is applied first so a same-edge alloc of the same register wins.
    always_comb begin
        w_allocOk  = allocEn && (allocReg != 5'd31);
        w_wrOk     = w_grant && (w_wrReg != 5'd31);
        w_pendNext = w_pendFull;
        if (w_wrOk) begin
            w_pendNext[w_wrReg] = 1'b0;
        end
        if (w_allocOk) begin
            w_pendNext[allocReg] = 1'b1;
        end
        w_pendNext[31] = 1'b0;
        w_set = w_allocOk && !w_pendFull[allocReg];
        w_clr = w_wrOk && w_pendFull[w_wrReg] && !(w_allocOk && (allocReg == w_wrReg));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending   <= '0;
            r_pendCount <= '0;
            r_lastGrant <= GRANT_B;
        end else begin
            r_pending   <= w_pendNext[30:0];
            r_pendCount <= r_pendCount + {5'd0, w_set} - {5'd0, w_clr};
            if (w_grantA) begin
                r_lastGrant <= GRANT_A;
            end else if (w_grantB) begin
                r_lastGrant <= GRANT_B;
            end
        end
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench for regwr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of grants and the pending-register set.
module tb_regwr_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         aValid, bValid, allocEn;
    logic [4:0]   aReg, bReg, allocReg, qReg0, qReg1;
    logic [W-1:0] aData, bData;
    logic         aReady, bReady, busy0, busy1, regWrEn;
    logic [5:0]   pendCount;
    logic [W-1:0] writeData;
    logic [4:0]   writeReg;

    int n_checks = 0;
    int n_errors = 0;

    // Model: set of pending registers and which requester should win the next contention.
    bit m_pend[32];
    bit m_preferA;

    logic         obs_aReady, obs_bReady, obs_regWrEn, obs_busy0;
    logic [4:0]   obs_wreg;
    logic [5:0]   obs_cnt;

    regwr_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
        .allocEn(allocEn), .allocReg(allocReg),
        .qReg0(qReg0), .qReg1(qReg1), .busy0(busy0), .busy1(busy1),
        .pendCount(pendCount), .writeData(writeData), .writeReg(writeReg), .regWrEn(regWrEn)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_preferA = 1'b1;
    endtask

    task automatic idle_inputs();
        aValid = 0; bValid = 0; allocEn = 0;
        aReg = '0; bReg = '0; allocReg = '0; aData = '0; bData = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        int           g;
        logic [4:0]   ereg;
        logic [W-1:0] edata;
        @(negedge clk);
        if (aValid && bValid) g = m_preferA ? 1 : 2;
        else if (aValid)      g = 1;
        else if (bValid)      g = 2;
        else                  g = 0;
        ereg  = (g == 1) ? aReg  : (g == 2) ? bReg  : 5'd0;
        edata = (g == 1) ? aData : (g == 2) ? bData : '0;
        obs_aReady = aReady; obs_bReady = bReady; obs_regWrEn = regWrEn;
        obs_wreg = writeReg; obs_busy0 = busy0; obs_cnt = pendCount;
        check_val("aReady", aReady, (g == 1));
        check_val("bReady", bReady, (g == 2));
        check_val("writeReg", writeReg, ereg);
        check_val("writeData", writeData, edata);
        check_val("regWrEn", regWrEn, (g != 0) && (ereg != 5'd31));
        check_val("busy0", busy0, (qReg0 != 5'd31) && m_pend[qReg0]);
        check_val("busy1", busy1, (qReg1 != 5'd31) && m_pend[qReg1]);
        check_val("pendCount", pendCount, model_count());
        @(posedge clk);
        if (g != 0) begin
            m_preferA = (g == 2);
            if (ereg != 5'd31) m_pend[ereg] = 1'b0;
        end
        if (allocEn && allocReg != 5'd31) m_pend[allocReg] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_val("rst_pendCount", pendCount, 0);
        check_val("rst_regWrEn", regWrEn, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a_hold, b_hold;
        int a_wait;
        reset_n = 1'b0;
        idle_inputs();
        qReg0 = '0; qReg1 = '0;
        model_reset();
        #12;
        // Inputs active during reset must be ignored.
        aValid = 1; bValid = 1; aReg = 5'd3; aData = 64'h55;
        #1;
        check_val("rst_aReady", aReady, 0);
        check_val("rst_bReady", bReady, 0);
        check_val("rst_writeReg", writeReg, 0);
        check_val("rst_writeData", writeData, 0);
        check_val("rst_busy0", busy0, 0);
        idle_inputs();
        do_reset();

        // Single A write right after reset
        aValid = 1; aReg = 5'd5; aData = 64'hAA;
        step();
        check_val("t040_aReady", obs_aReady, 1);
        check_val("t040_regWrEn", obs_regWrEn, 1);
        check_val("t040_wreg", obs_wreg, 5);
        idle_inputs();

        // Round-robin under sustained contention
        do_reset();
        aValid = 1; bValid = 1; aReg = 5'd3; bReg = 5'd4; aData = 64'h3333; bData = 64'h4444;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t041_wreg", obs_wreg, (i % 2 == 0) ? 5'd3 : 5'd4);
        end
        idle_inputs();

        // Alloc then clear by B write
        allocEn = 1; allocReg = 5'd7; qReg0 = 5'd7;
        step();
        allocEn = 0; bValid = 1; bReg = 5'd7; bData = 64'h77;
        step();
        check_val("t042_busy_set", obs_busy0, 1);
        check_val("t042_cnt_set", obs_cnt, 1);
        idle_inputs();
        step();
        check_val("t042_busy_clr", obs_busy0, 0);
        check_val("t042_cnt_clr", obs_cnt, 0);

        // Same-edge alloc and write of reg 9
        allocEn = 1; allocReg = 5'd9; qReg0 = 5'd9;
        step();
        aValid = 1; aReg = 5'd9; aData = 64'h99;
        step();
        idle_inputs();
        step();
        check_val("t043_busy", obs_busy0, 1);
        check_val("t043_cnt", obs_cnt, 1);

        // Register 31 handling
        do_reset();
        aValid = 1; aReg = 5'd31; aData = 64'h31;
        step();
        check_val("t044_aReady", obs_aReady, 1);
        check_val("t044_regWrEn", obs_regWrEn, 0);
        idle_inputs();
        allocEn = 1; allocReg = 5'd31; qReg0 = 5'd31;
        step();
        idle_inputs();
        step();
        check_val("t044_cnt", obs_cnt, 0);
        check_val("t044_busy", obs_busy0, 0);

        // Fill the scoreboard, then asynchronous reset mid-cycle
        for (int r = 0; r < 31; r++) begin
            allocEn = 1; allocReg = 5'(r);
            step();
        end
        idle_inputs();
        qReg0 = 5'd3; qReg1 = 5'd30;
        step();
        check_val("t045_cnt_full", obs_cnt, 31);
        #2;
        aValid = 1; aReg = 5'd2; aData = 64'hBEEF;
        reset_n = 1'b0;
        #1;
        check_val("t045_cnt_rst", pendCount, 0);
        check_val("t045_busy0_rst", busy0, 0);
        check_val("t045_busy1_rst", busy1, 0);
        check_val("t045_aReady_rst", aReady, 0);
        check_val("t045_wdata_rst", writeData, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Randomized traffic; requesters hold their payload until accepted
        a_hold = 0; b_hold = 0; a_wait = 0;
        for (int c = 0; c < 600; c++) begin
            if (!a_hold) begin
                aValid = ($urandom_range(0, 3) != 0);
                aReg = 5'($urandom_range(0, 31));
                aData = {$urandom, $urandom};
            end
            if (!b_hold) begin
                bValid = ($urandom_range(0, 3) != 0);
                bReg = 5'($urandom_range(0, 31));
                bData = {$urandom, $urandom};
            end
            allocEn = ($urandom_range(0, 1) != 0);
            allocReg = 5'($urandom_range(0, 31));
            qReg0 = 5'($urandom_range(0, 31));
            qReg1 = 5'($urandom_range(0, 31));
            step();
            a_hold = aValid && !obs_aReady;
            b_hold = bValid && !obs_bReady;
            a_wait = a_hold ? a_wait + 1 : 0;
            if (a_wait > 1) check_val("starveA", a_wait, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, data width of the register-file write port.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 aValid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 aReg  input  5  requester A destination register.
REQ-006 aData  input  WIDTH  requester A write data.
REQ-007 aReady  output  1  requester A write accepted this cycle.
REQ-008 bValid  input  1  requester B (load writeback) has a write pending.
REQ-009 bReg  input  5  requester B destination register.
REQ-010 bData  input  WIDTH  requester B write data.
REQ-011 bReady  output  1  requester B write accepted this cycle.
REQ-012 allocEn  input  1  issue stage marks allocReg as pending.
REQ-013 allocReg  input  5  register to mark pending.
REQ-014 qReg0, qReg1  input  5 each  scoreboard query registers (decode read operands).
REQ-015 busy0, busy1  output  1 each  queried register has an outstanding write.
REQ-016 pendCount  output  6  number of registers currently marked pending.
REQ-017 writeData  output  WIDTH  to regfile write data.
REQ-018 writeReg  output  5  to regfile write register select.
REQ-019 regWrEn  output  1  to regfile write enable.

Function
REQ-020 At most one requester granted per cycle; grant combinational from aValid/bValid and state lastGrant.
REQ-021 Only one valid -> that one granted.
REQ-022 Both valid -> grant the requester not in lastGrant (round-robin); lastGrant updates to the granted requester at the clock edge.
REQ-023 Neither valid -> no grant, lastGrant holds.
REQ-024 aReady/bReady = 1 exactly in the cycle that requester is granted; a transfer completes when valid && ready at the rising edge.
REQ-025 Requesters hold reg/data stable while valid && !ready; arbiter latency = 0 cycles (regfile written at the same edge as acceptance).
REQ-026 writeReg/writeData = granted requester's reg/data; 0 when no grant.
REQ-027 regWrEn = 1 when a grant exists and writeReg != 31; write to register 31 accepted (ready=1) but regWrEn = 0.
REQ-028 Scoreboard: 31 pending bits (registers 0..30); register 31 never pending.
REQ-029 Accepted write to register r clears pending[r] at that edge.
REQ-030 allocEn with allocReg != 31 sets pending[allocReg] at the edge; allocReg = 31 ignored.
REQ-031 Same-edge alloc and clear of the same register -> pending stays/becomes 1 (alloc wins).
REQ-032 Alloc of an already-pending register -> remains 1, pendCount unchanged.
REQ-033 Write to a non-pending register -> still performed, pendCount unchanged.
REQ-034 busy0 = pending[qReg0], busy1 = pending[qReg1], combinational from current state (no same-cycle bypass); qReg = 31 -> 0.
REQ-035 pendCount = population count of pending bits, registered, range 0..31, no wrap; updated same edge as pending bits (+1, -1, or net 0 on simultaneous set/clear of different registers).
REQ-036 Starvation bound: continuously valid requester granted within 2 cycles.

Reset
REQ-037 reset_n low -> all pending bits 0, pendCount 0, lastGrant = B (A wins first contention), immediately and asynchronously.
REQ-038 During reset: aReady, bReady, regWrEn = 0, writeReg = 0, writeData = 0, busy0/busy1 = 0; inputs ignored.
REQ-039 Reset asserted mid-contention -> pending transfers dropped; after deassertion arbitration restarts with A priority.

Verification
REQ-040 After reset, aValid=1 aReg=5 aData=0xAA, bValid=0 -> aReady=1, regWrEn=1, writeReg=5, writeData=0xAA same cycle.
REQ-041 aValid=bValid=1 held 4 cycles, regs 3/4 -> grants A,B,A,B; writeReg 3,4,3,4.
REQ-042 allocEn reg 7, then query qReg0=7 -> busy0=1, pendCount=1; B writes reg 7 -> next cycle busy0=0, pendCount=0.
REQ-043 Same edge allocEn reg 9 and A write reg 9 (pending) -> pending[9]=1, pendCount unchanged.
REQ-044 A writes reg 31 -> aReady=1, regWrEn=0; allocEn reg 31 -> pendCount stays 0, busy for qReg=31 = 0.
REQ-045 Alloc regs 0..30 -> pendCount=31; reset_n pulse low mid-cycle -> pendCount=0 and busy outputs 0 before next edge.
